// File: rtl/match_game_ctrl.sv
// ---------------------------------------------------------------------------
// match_game_ctrl
//   Round sequencer for the two-player sequence-matching game. The setter
//   loads SEQ_LEN 4-bit symbols into an external bank of load registers, and
//   the guesser then replays them. Each symbol is compared against the stored
//   slot. The block enforces a per-phase time limit, keeps both scores, swaps
//   roles after every round and declares a winner.
//
// Optional feature (compile-time macro RETRY_EN):
//   When defined, the guesser gets one retry per round. The first mismatch
//   restarts the guess at slot 0 and does not reset the timer.
//
// Ports
//   Clk         rising-edge clock
//   Rst         synchronous reset, active-high
//   Start       begin game (IDLE) / restart (OVER)
//   P1Valid/P1Data, P2Valid/P2Data   player symbol strobes
//   StoredData  load-register outputs, slot i at [4i+3:4i]
//   LoadData    setter's symbol to all load-register inputs (combinational)
//   Allow       load-register enable; low clears the bank on the next edge
//   Access      one-hot slot write strobe (combinational, SET only)
//   Turn        current setter: 0 = P1, 1 = P2
//   Phase       IDLE=0, SET=1, GUESS=2, CLEAR=3, OVER=4
//   P1Score, P2Score   saturating scores
//   Timeout     one-cycle pulse after a phase runs out of time
//   Winner      valid in OVER: 0 = P1, 1 = P2
// ---------------------------------------------------------------------------
module match_game_ctrl #(
  parameter int SEQ_LEN     = 4,
  parameter int TURN_CYCLES = 1000,
  parameter int WIN_SCORE   = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 P1Valid,
  input  logic [3:0]           P1Data,
  input  logic                 P2Valid,
  input  logic [3:0]           P2Data,
  input  logic [4*SEQ_LEN-1:0] StoredData,
  output logic [3:0]           LoadData,
  output logic                 Allow,
  output logic [SEQ_LEN-1:0]   Access,
  output logic                 Turn,
  output logic [2:0]           Phase,
  output logic [3:0]           P1Score,
  output logic [3:0]           P2Score,
  output logic                 Timeout,
  output logic                 Winner
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SET   = 3'd1;
  localparam logic [2:0] PH_GUESS = 3'd2;
  localparam logic [2:0] PH_CLEAR = 3'd3;
  localparam logic [2:0] PH_OVER  = 3'd4;

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TW = $clog2(TURN_CYCLES + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(SEQ_LEN - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TURN_CYCLES);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  logic [2:0]    phase_q;
  logic          turn_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    p1_score_q;
  logic [3:0]    p2_score_q;
  logic          timeout_q;
  logic          winner_q;

  logic          in_set;
  logic          in_guess;
  logic          active_valid;
  logic [3:0]    guess_data;
  logic [3:0]    stored_sym;
  logic          idx_last;
  logic          time_up;
  logic          match;
  logic          retry_avail;
  logic          award_setter;
  logic          award_guesser;
  logic          award_p1;
  logic          award_p2;

`ifdef RETRY_EN
  logic retry_used_q;
  assign retry_avail = !retry_used_q;
`else
  assign retry_avail = 1'b0;
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  assign in_set     = (phase_q == PH_SET);
  assign in_guess   = (phase_q == PH_GUESS);
  assign guess_data = turn_q ? P1Data : P2Data;
  assign stored_sym = StoredData[{idx_q, 2'b00} +: 4];
  assign idx_last   = (idx_q == IDX_LAST);
  // The timer saturates past the limit, so a valid accepted on the final
  // cycle does not disable the limit: the next idle cycle still times out.
  assign time_up    = (timer_q >= TIMER_END);
  assign match      = (guess_data == stored_sym);

  // Only the setter's strobe counts in SET and only the guesser's in GUESS.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through it leaves a value unassigned (which would infer a latch).
    active_valid = 1'b0;
    if (in_set)   active_valid = turn_q ? P2Valid : P1Valid;
    if (in_guess) active_valid = turn_q ? P1Valid : P2Valid;
  end

  // Round outcome, resolved to "setter" / "guesser" and then to a player.
  always_comb begin
    award_setter  = 1'b0;
    award_guesser = 1'b0;
    if (in_set && !active_valid && time_up) award_guesser = 1'b1;
    if (in_guess) begin
      if (!active_valid) begin
        if (time_up) award_setter = 1'b1;
      end else if (match) begin
        if (idx_last) award_guesser = 1'b1;
      end else if (!retry_avail) begin
        award_setter = 1'b1;
      end
    end
    award_p1 = turn_q ? award_guesser : award_setter;
    award_p2 = turn_q ? award_setter  : award_guesser;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      phase_q    <= PH_IDLE;
      turn_q     <= 1'b0;
      idx_q      <= '0;
      timer_q    <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      timeout_q  <= 1'b0;
      winner_q   <= 1'b0;
`ifdef RETRY_EN
      retry_used_q <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values; later assignments in this block override
      // earlier defaults for the same register.
      timeout_q <= 1'b0;
      if (award_p1) p1_score_q <= sat_inc(p1_score_q);
      if (award_p2) p2_score_q <= sat_inc(p2_score_q);

      case (phase_q)
        PH_IDLE: begin
          if (Start) begin
            phase_q <= PH_SET;
            idx_q   <= '0;
            timer_q <= '0;
          end
        end

        PH_SET, PH_GUESS: begin
          if (timer_q != TIMER_MAX) timer_q <= timer_q + TW'(1);
          if (active_valid) begin
            if (in_set) begin
              if (idx_last) begin
                phase_q <= PH_GUESS;
                idx_q   <= '0;
                timer_q <= '0;
`ifdef RETRY_EN
                retry_used_q <= 1'b0;
`endif
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else if (match) begin
              if (idx_last) phase_q <= PH_CLEAR;
              else          idx_q   <= idx_q + IW'(1);
            end else if (retry_avail) begin
`ifdef RETRY_EN
              retry_used_q <= 1'b1;
`endif
              idx_q <= '0;
            end else begin
              phase_q <= PH_CLEAR;
            end
          end else if (time_up) begin
            timeout_q <= 1'b1;
            phase_q   <= PH_CLEAR;
          end
        end

        // Allow is low for this one cycle, which wipes the load registers.
        PH_CLEAR: begin
          if (p1_score_q >= WIN || p2_score_q >= WIN) begin
            phase_q  <= PH_OVER;
            winner_q <= (p1_score_q < WIN);
          end else begin
            turn_q  <= ~turn_q;
            phase_q <= PH_SET;
            idx_q   <= '0;
            timer_q <= '0;
          end
        end

        PH_OVER: begin
          if (Start) begin
            p1_score_q <= '0;
            p2_score_q <= '0;
            turn_q     <= 1'b0;
            winner_q   <= 1'b0;
            phase_q    <= PH_SET;
            idx_q      <= '0;
            timer_q    <= '0;
          end
        end

        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign LoadData = turn_q ? P2Data : P1Data;
  assign Allow    = in_set || in_guess;
  assign Access   = (in_set && active_valid) ? (SEQ_LEN'(1) << idx_q) : '0;
  assign Turn     = turn_q;
  assign Phase    = phase_q;
  assign P1Score  = p1_score_q;
  assign P2Score  = p2_score_q;
  assign Timeout  = timeout_q;
  assign Winner   = winner_q;

endmodule
